// File: rtl/btb_update_scheduler_pkg.sv
// Shared types for the BTB update path: scheduler states, queued update entry,
// BTB tag width and a saturating counter helper.
package FetchUnitTypes;

  localparam int unsigned BTB_TAG_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } btb_sched_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } btb_upd_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/btb_update_queue.sv
// Circular FIFO of pending BTB updates: up to WR_PORTS pushes per cycle packed
// in port order, one pop per cycle. DEPTH must be a power of two, >= 2.
module btb_update_queue
  import FetchUnitTypes::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WR_PORTS = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [WR_PORTS-1:0]          wr_en_i,
  input  btb_upd_t [WR_PORTS-1:0]      wr_data_i,
  input  logic                         rd_en_i,
  output btb_upd_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  btb_upd_t          mem_q [DEPTH];
  btb_upd_t          mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  n_wr_s;
  logic              deq_s;

  // Pack the enabled write ports into consecutive slots after the tail.
  always_comb begin
    mem_d  = mem_q;
    n_wr_s = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en_i[p]) begin
        mem_d[wr_ptr_q + PTR_W'(n_wr_s)] = wr_data_i[p];
        n_wr_s = n_wr_s + CNT_W'(1);
      end else begin
        n_wr_s = n_wr_s;
      end
    end
  end

  assign deq_s    = rd_en_i && (count_q != '0);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(n_wr_s);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(deq_s);
  assign count_d  = count_q + n_wr_s - CNT_W'(deq_s);

  // Queue state update; flush only rewinds pointers, stale data is unreachable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/btb_update_scheduler.sv
// Schedules BTB writes: an init sweep clearing every entry, then taken-branch
// updates drained through a queue around BTB reads. Optional: BTB_UPDATE_STATS_EN.
module btb_update_scheduler
  import FetchUnitTypes::*;
#(
  parameter int unsigned BR_PORTS    = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned BTB_ENTRIES = 512
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rstStart,
  input  logic [BR_PORTS-1:0]               brValid,
  input  logic [BR_PORTS-1:0]               brTaken,
  input  logic [BR_PORTS-1:0][31:0]         brPC,
  input  logic [BR_PORTS-1:0][31:0]         brTarget,
  output logic                              brReady,
  input  logic                              rdReq,
  output logic                              btbWE,
  output logic [$clog2(BTB_ENTRIES)-1:0]    btbWIndex,
  output logic [BTB_TAG_W-1:0]              btbWTag,
  output logic [31:0]                       btbWData,
  output logic                              btbWValid,
  output logic                              initBusy
`ifdef BTB_UPDATE_STATS_EN
  ,
  output logic [31:0]                       updCount,
  output logic [31:0]                       deferCount
`endif
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(BTB_ENTRIES - 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(QUEUE_DEPTH - BR_PORTS);

  btb_sched_state_e       state_q;
  logic [IDX_W-1:0]       init_cnt_q;
  btb_upd_t               head_s;
  logic [CNT_W-1:0]       count_s;
  logic [BR_PORTS-1:0]    enq_en_s;
  btb_upd_t [BR_PORTS-1:0] enq_data_s;
  logic                   run_wr_s;
  logic                   defer_s;

  // Scheduler FSM and init sweep counter; rstStart restarts the sweep anywhere.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      init_cnt_q <= '0;
    end else if (rstStart) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            state_q    <= ST_RUN;
            init_cnt_q <= '0;
          end else begin
            init_cnt_q <= init_cnt_q + IDX_W'(1);
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: begin
          state_q    <= ST_IDLE;
          init_cnt_q <= '0;
        end
      endcase
    end
  end

  assign brReady  = (state_q == ST_RUN) && (count_s <= READY_MAX);
  assign initBusy = (state_q == ST_INIT);

  // Accept only a whole group, and never in the cycle the queue is being flushed.
  always_comb begin
    for (int p = 0; p < BR_PORTS; p++) begin
      enq_en_s[p]          = brReady && !rstStart && brValid[p] && brTaken[p];
      enq_data_s[p].pc     = brPC[p];
      enq_data_s[p].target = brTarget[p];
    end
  end

  btb_update_queue #(
    .DEPTH    (QUEUE_DEPTH),
    .WR_PORTS (BR_PORTS)
  ) u_queue (
    .clk_i     (clk),
    .rst_ni    (rst),
    .flush_i   (rstStart),
    .wr_en_i   (enq_en_s),
    .wr_data_i (enq_data_s),
    .rd_en_i   (run_wr_s),
    .head_o    (head_s),
    .count_o   (count_s)
  );

  assign run_wr_s = (state_q == ST_RUN) && !rstStart && (count_s != '0) && !rdReq;
  assign defer_s  = (state_q == ST_RUN) && !rstStart && (count_s != '0) && rdReq;

  // Write port mux: sweep clears entries, run mode writes the queue head.
  always_comb begin
    btbWE     = 1'b0;
    btbWIndex = '0;
    btbWTag   = '0;
    btbWData  = 32'd0;
    btbWValid = 1'b0;
    case (state_q)
      ST_INIT: begin
        btbWE     = 1'b1;
        btbWIndex = init_cnt_q;
      end
      ST_RUN: begin
        if (run_wr_s) begin
          btbWE     = 1'b1;
          btbWValid = 1'b1;
          btbWIndex = head_s.pc[IDX_W+1:2];
          btbWTag   = head_s.pc[IDX_W+BTB_TAG_W+1:IDX_W+2];
          btbWData  = head_s.target;
        end else begin
          btbWE     = 1'b0;
        end
      end
      default: btbWE = 1'b0;
    endcase
  end

`ifdef BTB_UPDATE_STATS_EN
  logic [31:0] upd_cnt_q;
  logic [31:0] defer_cnt_q;

  // Saturating activity counters, cleared whenever the sweep restarts.
  always_ff @(posedge clk) begin
    if (!rst || rstStart) begin
      upd_cnt_q   <= 32'd0;
      defer_cnt_q <= 32'd0;
    end else begin
      if (run_wr_s) begin
        upd_cnt_q <= sat_inc32(upd_cnt_q);
      end
      if (defer_s) begin
        defer_cnt_q <= sat_inc32(defer_cnt_q);
      end
    end
  end

  assign updCount   = upd_cnt_q;
  assign deferCount = defer_cnt_q;
`else
  logic unused_defer_s;
  assign unused_defer_s = defer_s;
`endif

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Randomized scoreboard bench for btb_update_scheduler against a queue-based
// reference model; build with BTB_UPDATE_STATS_EN to also cover the counters.
module tb_btb_update_scheduler;

  localparam int BRP = 2;
  localparam int QD  = 4;
  localparam int ENT = 512;
  localparam int IW  = $clog2(ENT);

  localparam int M_IDLE = 0;
  localparam int M_INIT = 1;
  localparam int M_RUN  = 2;

  typedef struct {
    int            cyc;
    bit [IW-1:0]   idx;
    bit [9:0]      tag;
    bit [31:0]     data;
    bit            valid;
  } wr_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 rst_start = 1'b0;
  logic [1:0]           br_valid = 2'b00;
  logic [1:0]           br_taken = 2'b00;
  logic [1:0][31:0]     br_pc = '0;
  logic [1:0][31:0]     br_tgt = '0;
  logic                 rd_req = 1'b0;
  logic                 br_ready;
  logic                 btb_we;
  logic [IW-1:0]        w_idx;
  logic [9:0]           w_tag;
  logic [31:0]          w_data;
  logic                 w_valid;
  logic                 init_busy;
`ifdef BTB_UPDATE_STATS_EN
  logic [31:0]          upd_count;
  logic [31:0]          defer_count;
  int                   m_upd = 0;
  int                   m_defer = 0;
  int                   exp_upd = 0;
  int                   exp_defer = 0;
`endif

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  chk_on = 1'b0;

  wr_t       exp_q[$];
  bit [31:0] mq_pc[$];
  bit [31:0] mq_tg[$];
  int        m_mode = M_IDLE;
  int        m_init = 0;
  bit        exp_ready = 1'b0;
  bit        exp_busy = 1'b0;

  btb_update_scheduler #(
    .BR_PORTS    (BRP),
    .QUEUE_DEPTH (QD),
    .BTB_ENTRIES (ENT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rstStart  (rst_start),
    .brValid   (br_valid),
    .brTaken   (br_taken),
    .brPC      (br_pc),
    .brTarget  (br_tgt),
    .brReady   (br_ready),
    .rdReq     (rd_req),
    .btbWE     (btb_we),
    .btbWIndex (w_idx),
    .btbWTag   (w_tag),
    .btbWData  (w_data),
    .btbWValid (w_valid),
    .initBusy  (init_busy)
`ifdef BTB_UPDATE_STATS_EN
    ,
    .updCount   (upd_count),
    .deferCount (defer_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: predicts this cycle's outputs from the applied inputs,
  // then advances to the next cycle.
  task automatic model_step();
    wr_t w;
    bit  wrote;
    bit  defer;
    exp_ready = (m_mode == M_RUN) && ((QD - mq_pc.size()) >= BRP);
    exp_busy  = (m_mode == M_INIT);
`ifdef BTB_UPDATE_STATS_EN
    exp_upd   = m_upd;
    exp_defer = m_defer;
`endif
    wrote = 1'b0;
    defer = (m_mode == M_RUN) && !rst_start && (mq_pc.size() > 0) && rd_req;
    if (m_mode == M_INIT) begin
      w.cyc = cyc; w.idx = IW'(m_init); w.tag = '0; w.data = '0; w.valid = 1'b0;
      exp_q.push_back(w);
    end else if (m_mode == M_RUN && !rst_start && mq_pc.size() > 0 && !rd_req) begin
      w.cyc   = cyc;
      w.idx   = IW'((mq_pc[0] >> 2) % ENT);
      w.tag   = 10'((mq_pc[0] >> (2 + IW)) % 1024);
      w.data  = mq_tg[0];
      w.valid = 1'b1;
      exp_q.push_back(w);
      wrote = 1'b1;
    end
    if (!rst) begin
      m_mode = M_IDLE; m_init = 0; mq_pc.delete(); mq_tg.delete();
`ifdef BTB_UPDATE_STATS_EN
      m_upd = 0; m_defer = 0;
`endif
    end else if (rst_start) begin
      m_mode = M_INIT; m_init = 0; mq_pc.delete(); mq_tg.delete();
`ifdef BTB_UPDATE_STATS_EN
      m_upd = 0; m_defer = 0;
`endif
    end else if (m_mode == M_INIT) begin
      if (m_init == ENT - 1) m_mode = M_RUN;
      else m_init++;
    end else if (m_mode == M_RUN) begin
      if (wrote) begin
        void'(mq_pc.pop_front()); void'(mq_tg.pop_front());
`ifdef BTB_UPDATE_STATS_EN
        m_upd++;
`endif
      end
`ifdef BTB_UPDATE_STATS_EN
      if (defer) m_defer++;
`endif
      if (exp_ready) begin
        for (int p = 0; p < BRP; p++) begin
          if (br_valid[p] && br_taken[p]) begin
            mq_pc.push_back(br_pc[p]);
            mq_tg.push_back(br_tgt[p]);
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input bit [1:0] v, input bit [1:0] t,
                      input bit [31:0] p0, input bit [31:0] p1,
                      input bit [31:0] g0, input bit [31:0] g1, input bit rd);
    @(posedge clk);
    #1;
    rst = r; rst_start = s; br_valid = v; br_taken = t;
    br_pc[0] = p0; br_pc[1] = p1; br_tgt[0] = g0; br_tgt[1] = g1; rd_req = rd;
    model_step();
  endtask

  task automatic rand_step(input bit r, input bit s, input int rd_pct);
    step(r, s, 2'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
         ($urandom_range(0, 99) < rd_pct));
  endtask

  // Monitor: compares DUT outputs against model predictions every cycle.
  always @(negedge clk) begin
    wr_t e;
    if (chk_on) begin
      checks++;
      if (br_ready !== exp_ready) begin
        errors++;
        $display("FAIL brReady cyc=%0d got=%b exp=%b", cyc, br_ready, exp_ready);
      end
      checks++;
      if (init_busy !== exp_busy) begin
        errors++;
        $display("FAIL initBusy cyc=%0d got=%b exp=%b", cyc, init_busy, exp_busy);
      end
`ifdef BTB_UPDATE_STATS_EN
      checks++;
      if (upd_count !== 32'(exp_upd) || defer_count !== 32'(exp_defer)) begin
        errors++;
        $display("FAIL stats cyc=%0d got upd=%0d defer=%0d exp upd=%0d defer=%0d",
                 cyc, upd_count, defer_count, exp_upd, exp_defer);
      end
`endif
      if (btb_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d got idx=%h tag=%h data=%h valid=%b exp none",
                   cyc, w_idx, w_tag, w_data, w_valid);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || w_idx !== e.idx || w_tag !== e.tag ||
              w_data !== e.data || w_valid !== e.valid) begin
            errors++;
            $display("FAIL write cyc=%0d got idx=%h tag=%h data=%h valid=%b exp cyc=%0d idx=%h tag=%h data=%h valid=%b",
                     cyc, w_idx, w_tag, w_data, w_valid, e.cyc, e.idx, e.tag, e.data, e.valid);
          end
        end
      end else begin
        checks++;
        if (btb_we !== 1'b0 || w_idx !== '0 || w_tag !== '0 || w_data !== '0 || w_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs cyc=%0d got we=%b idx=%h tag=%h data=%h valid=%b exp all 0",
                   cyc, btb_we, w_idx, w_tag, w_data, w_valid);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_write cyc=%0d got we=0 exp idx=%h tag=%h data=%h valid=%b",
                   cyc, e.idx, e.tag, e.data, e.valid);
        end
      end
    end
  end

  initial begin
    // Reset, then an idle cycle with branch traffic that must be ignored.
    rand_step(1'b0, 1'b0, 0);
    rand_step(1'b0, 1'b0, 0);
    chk_on = 1'b1;
    rand_step(1'b1, 1'b0, 50);
    rand_step(1'b1, 1'b0, 50);

    // First init sweep with noise on every input.
    step(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < ENT + 1; i++) rand_step(1'b1, 1'b0, 50);
    step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

    // Single taken branch on port 0.
    step(1'b1, 1'b0, 2'b01, 2'b01, 32'h0000_1000, 32'h0, 32'h0000_2000, 32'h0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

    // Both ports taken; also a not-taken valid result in the mix.
    step(1'b1, 1'b0, 2'b11, 2'b11, 32'h0040_0ABC, 32'h1234_5678, 32'hCAFE_0000, 32'hBEEF_0004, 1'b0);
    step(1'b1, 1'b0, 2'b11, 2'b01, 32'h0000_3004, 32'h0000_3008, 32'h0000_5000, 32'h0000_6000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

    // Read port busy for 6 cycles while feeding two taken per cycle, then drain.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 2'b11, 2'b11, $urandom, $urandom, $urandom, $urandom, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

    // Three entries queued behind rdReq, then rstStart flushes them.
    step(1'b1, 1'b0, 2'b11, 2'b11, $urandom, $urandom, $urandom, $urandom, 1'b1);
    step(1'b1, 1'b0, 2'b01, 2'b01, $urandom, $urandom, $urandom, $urandom, 1'b1);
    step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    step(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < ENT + 2; i++) rand_step(1'b1, 1'b0, 50);

    // Random run-mode traffic.
    for (int i = 0; i < 1500; i++) rand_step(1'b1, 1'b0, 40);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);

    // Reset asserted while the sweep writes index 100.
    step(1'b1, 1'b1, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 100; i++) rand_step(1'b1, 1'b0, 50);
    step(1'b0, 1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) rand_step(1'b1, 1'b0, 50);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_scheduler.md
BTB_UPDATE_SCHEDULER -- requirements
Module: btb_update_scheduler

Interface
REQ-001 SHALL have parameter BR_PORTS, default 2: branch-result ports per cycle.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4: update-queue entries, power of two, at least BR_PORTS.
REQ-003 SHALL have parameter BTB_ENTRIES, default 512: BTB index count, power of two.
REQ-004 SHALL have one clock and one reset, reset synchronous and active-low: clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have: rstStart  in  1  one-cycle pulse that starts the BTB init sweep.
REQ-007 SHALL have: brValid  in  BR_PORTS  per-port executed-branch valid.
REQ-008 SHALL have: brTaken  in  BR_PORTS  per-port taken flag.
REQ-009 SHALL have: brPC  in  BR_PORTS x 32  branch PC.
REQ-010 SHALL have: brTarget  in  BR_PORTS x 32  resolved target.
REQ-011 SHALL have: brReady  out  1  all ports may present this cycle.
REQ-012 SHALL have: rdReq  in  1  BTB read port busy this cycle; defers writes.
REQ-013 SHALL have: btbWE  out  1  BTB write strobe.
REQ-014 SHALL have: btbWIndex  out  log2(BTB_ENTRIES)  write index.
REQ-015 SHALL have: btbWTag  out  10  write tag.
REQ-016 SHALL have: btbWData  out  32  write target.
REQ-017 SHALL have: btbWValid  out  1  entry valid bit written.
REQ-018 SHALL have: initBusy  out  1  init sweep in progress.

Function
REQ-019 SHALL use states IDLE, INIT, RUN: IDLE->INIT on rstStart; INIT->RUN after the last index is written; rstStart in any state->INIT with the queue flushed.
REQ-020 SHALL in INIT write index 0 up to BTB_ENTRIES-1, one per cycle: btbWE=1, btbWValid=0, btbWTag=0, btbWData=0; rdReq ignored; initBusy=1.
REQ-021 SHALL hold brReady=0 in IDLE and INIT; in RUN brReady=1 iff free slots at cycle start >= BR_PORTS.
REQ-022 SHALL in RUN enqueue only entries with brValid&brTaken, in ascending port order; not-taken results are discarded.
REQ-023 SHALL ignore presented results when brReady=0; no partial enqueue.
REQ-024 SHALL in RUN, when the queue is non-empty and rdReq=0, write the head entry: btbWE=1, btbWValid=1, btbWIndex=PC[log2(BTB_ENTRIES)+1:2], btbWTag=next 10 PC bits, btbWData=target; then dequeue it.
REQ-025 SHALL hold the head entry while rdReq=1 (btbWE=0, no loss).
REQ-026 SHALL set minimum latency from acceptance at cycle t to btbWE at t+1.
REQ-027 SHALL allow enqueue and dequeue in the same cycle; count += enq - deq; pointers wrap modulo QUEUE_DEPTH.
REQ-028 SHALL present all write outputs as 0 whenever btbWE=0.

Reset
REQ-029 SHALL on rst=0 at a clock edge set: state IDLE, queue empty, pointers 0, init counter 0, brReady=0, btbWE=0, initBusy=0, all write outputs 0, counters 0.
REQ-030 SHALL on rst=0 mid-INIT or mid-RUN abort the sweep and drop queued updates, without waiting for completion.

Configuration
REQ-031 SHALL, with BTB_UPDATE_STATS_EN defined, add outputs updCount (32, BTB run-mode writes) and deferCount (32, cycles head blocked by rdReq); both saturate and clear on reset and rstStart.
REQ-032 SHALL, without BTB_UPDATE_STATS_EN, omit both ports and their logic, with behaviour otherwise identical.

Structure
REQ-033 SHALL place the state enum, queue entry struct (pc, target) and the tag width constant 10 in FetchUnitTypes.
REQ-034 SHALL implement the queue as sub-module btb_update_queue (multi-write, single-read circular FIFO); the state machine and init counter stay in the top.

Verification
REQ-035 SHALL test: rstStart after reset -> 512 consecutive btbWE cycles, index 0..511, btbWValid=0, then initBusy=0 and brReady=1.
REQ-036 SHALL test: RUN, port0 taken PC=0x1000/target 0x2000 -> next cycle btbWE=1, index=0x000, tag=0x002, data=0x2000, valid=1.
REQ-037 SHALL test: both ports taken at the same time, rdReq=0 -> port0 write then port1 write on consecutive cycles.
REQ-038 SHALL test: rdReq held high for 6 cycles while feeding 2 taken per cycle -> brReady drops after queue reaches 3+ entries, no updates lost, FIFO drains in order once rdReq=0.
REQ-039 SHALL test: rstStart with 3 entries queued -> queue flushed, sweep restarts at index 0, none of the old entries are written.
REQ-040 SHALL test: rst=0 during INIT at index 100 -> next cycle IDLE, btbWE=0; with STATS_EN, counters read 0.
